// File: rtl/rgb_to_yuv_encoder_if.sv
// Bus bundle between the RGB->YUV encoder and the shared SRAM / top FSM.
// The master side is the encoder: it drives the SRAM address, write data,
// write strobe and the completion flag, and receives the enable request and
// the SRAM read data.
interface rgb_to_yuv_encoder_if;
  logic        enable;
  logic        stop;
  logic [15:0] SRAM_read;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_write_en;

  modport master (
    input  enable,
    input  SRAM_read,
    output stop,
    output SRAM_address,
    output SRAM_write_data,
    output SRAM_write_en
  );

  modport slave (
    output enable,
    output SRAM_read,
    input  stop,
    input  SRAM_address,
    input  SRAM_write_data,
    input  SRAM_write_en
  );
endinterface

// File: rtl/rgb_to_yuv_encoder.sv
// RGB -> YUV 4:2:2 encoder. Reads interleaved RGB pixel pairs from SRAM,
// computes Y per pixel and U/V per pair (horizontal pair sum), and writes the
// planar Y/U/V layout back into SRAM. One pixel pair takes a fixed 11-cycle
// loop; U/V bytes of an even pair are held until the odd pair completes the
// shared chroma word.
module rgb_to_yuv_encoder #(
  parameter logic [17:0] RGB_START_ADDRESS = 18'd146944,
  parameter logic [17:0] Y_START_ADDRESS   = 18'd0,
  parameter logic [17:0] U_START_ADDRESS   = 18'd38400,
  parameter logic [17:0] V_START_ADDRESS   = 18'd57600,
  parameter int          NUM_PAIRS         = 38400
) (
  input logic                    clock,
  input logic                    reset,
  rgb_to_yuv_encoder_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, DONE
  } state_t;

  localparam logic [17:0] LAST_PAIR = 18'(NUM_PAIRS - 1);

  // Conversion coefficients (fixed point, Y scaled by 2^16, U/V by 2^17
  // because they operate on two-pixel sums).
  localparam logic signed [31:0] C_YR     = 32'sd16843;
  localparam logic signed [31:0] C_YG     = 32'sd33030;
  localparam logic signed [31:0] C_YB     = 32'sd6423;
  localparam logic signed [31:0] C_UR     = -32'sd9699;
  localparam logic signed [31:0] C_UG     = -32'sd19071;
  localparam logic signed [31:0] C_UB     = 32'sd28770;
  localparam logic signed [31:0] C_VR     = 32'sd28770;
  localparam logic signed [31:0] C_VG     = -32'sd24117;
  localparam logic signed [31:0] C_VB     = -32'sd4653;
  localparam logic signed [31:0] Y_OFFSET = 32'sd1081344;
  localparam logic signed [31:0] C_OFFSET = 32'sd16842752;

  state_t             state_reg;
  logic [17:0]        pair_reg;
  logic [17:0]        rgb_addr_reg;
  logic [15:0]        word0_reg;
  logic [15:0]        word1_reg;
  logic [15:0]        word2_reg;
  logic [7:0]         y0_reg;
  logic [7:0]         u_reg;
  logic [7:0]         v_reg;
  logic [7:0]         u_hold_reg;
  logic [7:0]         v_hold_reg;
  logic signed [31:0] mult_a_reg [3];
  logic signed [31:0] mult_b_reg [3];
  logic [17:0]        address_reg;
  logic [15:0]        write_data_reg;
  logic               write_en_reg;
  logic               stop_reg;

  logic signed [31:0] prod [3];
  logic signed [31:0] mult_sum;
  logic [7:0]         luma;
  logic [7:0]         chroma;
  logic [7:0]         r0, g0, b0, r1, g1, b1;
  logic [8:0]         r_sum, g_sum, b_sum;

  function automatic logic [7:0] clip8(input logic signed [31:0] x);
    if (x < 0)
      return 8'd0;
    else if (x > 255)
      return 8'd255;
    else
      return x[7:0];
  endfunction

  function automatic logic signed [31:0] zext8(input logic [7:0] x);
    return {24'd0, x};
  endfunction

  function automatic logic signed [31:0] zext9(input logic [8:0] x);
    return {23'd0, x};
  endfunction

  // Unpack the three RGB words of the current pair.
  assign r0 = word0_reg[15:8];
  assign g0 = word0_reg[7:0];
  assign b0 = word1_reg[15:8];
  assign r1 = word1_reg[7:0];
  assign g1 = word2_reg[15:8];
  assign b1 = word2_reg[7:0];

  assign r_sum = {1'b0, r0} + {1'b0, r1};
  assign g_sum = {1'b0, g0} + {1'b0, g1};
  assign b_sum = {1'b0, b0} + {1'b0, b1};

  // Three signed multipliers on registered operands, truncated to 32 bits.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mult
    assign prod[gi] = mult_a_reg[gi] * mult_b_reg[gi];
  end

  assign mult_sum = prod[0] + prod[1] + prod[2];
  assign luma     = clip8((mult_sum + Y_OFFSET) >>> 16);
  assign chroma   = clip8((mult_sum + C_OFFSET) >>> 17);

  assign bus.SRAM_address    = address_reg;
  assign bus.SRAM_write_data = write_data_reg;
  assign bus.SRAM_write_en   = write_en_reg;
  assign bus.stop            = stop_reg;

  // Pair-loop FSM with registered SRAM outputs, operand loading and result latching.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pair_reg       <= '0;
      rgb_addr_reg   <= '0;
      word0_reg      <= '0;
      word1_reg      <= '0;
      word2_reg      <= '0;
      y0_reg         <= '0;
      u_reg          <= '0;
      v_reg          <= '0;
      u_hold_reg     <= '0;
      v_hold_reg     <= '0;
      for (int i = 0; i < 3; i++) begin
        mult_a_reg[i] <= '0;
        mult_b_reg[i] <= '0;
      end
      address_reg    <= '0;
      write_data_reg <= '0;
      write_en_reg   <= 1'b1;
      stop_reg       <= 1'b0;
    end else begin
      // The strobe is a one-cycle pulse following each write-issuing state.
      write_en_reg <= 1'b1;
      unique case (state_reg)
        IDLE: begin
          if (bus.enable) begin
            pair_reg     <= '0;
            rgb_addr_reg <= RGB_START_ADDRESS;
            state_reg    <= S0;
          end
        end
        S0: begin
          address_reg <= rgb_addr_reg;
          state_reg   <= S1;
        end
        S1: begin
          address_reg <= rgb_addr_reg + 18'd1;
          state_reg   <= S2;
        end
        S2: begin
          address_reg <= rgb_addr_reg + 18'd2;
          state_reg   <= S3;
        end
        S3: begin
          word0_reg <= bus.SRAM_read;
          state_reg <= S4;
        end
        S4: begin
          word1_reg <= bus.SRAM_read;
          state_reg <= S5;
        end
        S5: begin
          word2_reg     <= bus.SRAM_read;
          mult_a_reg[0] <= C_YR;
          mult_a_reg[1] <= C_YG;
          mult_a_reg[2] <= C_YB;
          mult_b_reg[0] <= zext8(r0);
          mult_b_reg[1] <= zext8(g0);
          mult_b_reg[2] <= zext8(b0);
          state_reg     <= S6;
        end
        S6: begin
          y0_reg        <= luma;
          mult_b_reg[0] <= zext8(r1);
          mult_b_reg[1] <= zext8(g1);
          mult_b_reg[2] <= zext8(b1);
          state_reg     <= S7;
        end
        S7: begin
          address_reg    <= Y_START_ADDRESS + pair_reg;
          write_data_reg <= {y0_reg, luma};
          write_en_reg   <= 1'b0;
          mult_a_reg[0]  <= C_UR;
          mult_a_reg[1]  <= C_UG;
          mult_a_reg[2]  <= C_UB;
          mult_b_reg[0]  <= zext9(r_sum);
          mult_b_reg[1]  <= zext9(g_sum);
          mult_b_reg[2]  <= zext9(b_sum);
          state_reg      <= S8;
        end
        S8: begin
          u_reg         <= chroma;
          mult_a_reg[0] <= C_VR;
          mult_a_reg[1] <= C_VG;
          mult_a_reg[2] <= C_VB;
          state_reg     <= S9;
        end
        S9: begin
          v_reg <= chroma;
          if (pair_reg[0]) begin
            address_reg    <= U_START_ADDRESS + (pair_reg >> 1);
            write_data_reg <= {u_hold_reg, u_reg};
            write_en_reg   <= 1'b0;
          end else begin
            u_hold_reg <= u_reg;
            v_hold_reg <= chroma;
          end
          state_reg <= S10;
        end
        S10: begin
          if (pair_reg[0]) begin
            address_reg    <= V_START_ADDRESS + (pair_reg >> 1);
            write_data_reg <= {v_hold_reg, v_reg};
            write_en_reg   <= 1'b0;
          end
          if (pair_reg == LAST_PAIR) begin
            state_reg <= DONE;
          end else begin
            pair_reg     <= pair_reg + 18'd1;
            rgb_addr_reg <= rgb_addr_reg + 18'd3;
            state_reg    <= S0;
          end
        end
        DONE: begin
          // stop is shown for at least one cycle before a release is honoured.
          stop_reg <= 1'b1;
          if (!bus.enable && stop_reg) begin
            stop_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
